// File: rtl/fnd_apb_arbiter.sv
// fnd_apb_arbiter
//   APB master that shares the 4-digit FND display slave between two requesters.
//   It picks a winner round-robin and latches the winner's value (saturated to
//   MAX_VAL), DP mask and enable. It then issues three APB writes: data at 0x4,
//   DP at 0x8 and control at 0x0. Finally it pulses the winner's ack for one cycle.
//
// Ports
//   PCLK, PRESET              clock, asynchronous active-high reset
//   reqN/valN/dpN/enN         requester N request and payload (N = 0, 1)
//   ackN                      one-cycle completion pulse to requester N
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE/PREADY       APB master interface (write-only)
//   busy                      high whenever the FSM is not idle
//   grant_id                  requester currently or last served
//   err                       sticky PREADY timeout flag, cleared on next grant
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches payload on grant
// SETUP  | APB setup phase for write idx
// ACCESS | APB access phase, waiting for PREADY or timeout
// DONE   | ack to the granted requester, update round-robin pointer

module fnd_apb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0,
  input  logic [13:0] val0,
  input  logic [3:0]  dp0,
  input  logic        en0,
  output logic        ack0,
  input  logic        req1,
  input  logic [13:0] val1,
  input  logic [3:0]  dp1,
  input  logic        en1,
  output logic        ack1,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic        PREADY,
  output logic        busy,
  output logic        grant_id,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [13:0]   r_val, w_val_nxt;
  logic [3:0]    r_dp, w_dp_nxt;
  logic          r_en, w_en_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_last, w_last_nxt;
  logic          r_err, w_err_nxt;
  logic          r_psel, w_psel_nxt;
  logic          r_penable, w_penable_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_ack0, w_ack0_nxt;
  logic          r_ack1, w_ack1_nxt;
  logic [3:0]    r_paddr, w_paddr_nxt;
  logic [31:0]   r_pwdata, w_pwdata_nxt;
  logic          w_gnt;
  logic [13:0]   w_req_val;

  // With both requesting, the one that was not served last wins.
  assign w_gnt     = (req0 && req1) ? ~r_last : req1;
  assign w_req_val = w_gnt ? val1 : val0;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    w_dp_nxt    = r_dp;
    w_en_nxt    = r_en;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant_nxt = w_gnt;
          w_val_nxt   = (w_req_val > 14'(MAX_VAL)) ? 14'(MAX_VAL) : w_req_val;
          w_dp_nxt    = w_gnt ? dp1 : dp0;
          w_en_nxt    = w_gnt ? en1 : en0;
          w_err_nxt   = 1'b0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = CW'(TIMEOUT - 1);
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (r_idx < 2'd2) begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (r_cnt == '0) begin
          // Slave never answered: skip any remaining writes.
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_last_nxt  = r_grant;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    w_psel_nxt    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable_nxt = (w_state_nxt == S_ACCESS);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_ack0_nxt    = (w_state_nxt == S_DONE) && !w_grant_nxt;
    w_ack1_nxt    = (w_state_nxt == S_DONE) && w_grant_nxt;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    if (w_state_nxt == S_SETUP) begin
      unique case (w_idx_nxt)
        2'd0: begin
          w_paddr_nxt  = 4'h4;
          w_pwdata_nxt = {18'b0, w_val_nxt};
        end
        2'd1: begin
          w_paddr_nxt  = 4'h8;
          w_pwdata_nxt = {28'b0, w_dp_nxt};
        end
        default: begin
          // Enable goes last so data and DP are in place before the display turns on.
          w_paddr_nxt  = 4'h0;
          w_pwdata_nxt = {31'b0, w_en_nxt};
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_val     <= 14'd0;
      r_dp      <= 4'd0;
      r_en      <= 1'b0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_busy    <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_paddr   <= 4'd0;
      r_pwdata  <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_val     <= w_val_nxt;
      r_dp      <= w_dp_nxt;
      r_en      <= w_en_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_err     <= w_err_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_busy    <= w_busy_nxt;
      r_ack0    <= w_ack0_nxt;
      r_ack1    <= w_ack1_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
    end
  end

  assign PSEL     = r_psel;
  assign PENABLE  = r_penable;
  assign PWRITE   = r_psel;
  assign PADDR    = r_paddr;
  assign PWDATA   = r_pwdata;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign busy     = r_busy;
  assign grant_id = r_grant;
  assign err      = r_err;

endmodule

// File: tb/tb_fnd_apb_arbiter.sv
// Testbench for fnd_apb_arbiter: APB slave model with configurable wait states,
// a round-robin reference model and scenario tasks with inline comparisons.

module tb_fnd_apb_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic        req0, req1, en0, en1;
  logic [13:0] val0, val1;
  logic [3:0]  dp0, dp1;
  logic        ack0, ack1;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic        PREADY = 1'b0;
  logic        busy, grant_id, err;

  int n_checks = 0;
  int n_fail   = 0;

  bit ready_en  = 1'b1;
  bit spur_en   = 1'b0;
  bit rand_wait = 1'b0;

  int          acc_cnt  = 0;
  int          wait_n   = 1;
  int          n_access = 0;
  int          n_setup  = 0;
  int          viol     = 0;
  logic [3:0]  su_addr  = 4'd0;
  logic [31:0] su_data  = 32'd0;
  logic [35:0] wr_q[$];

  int pv[2];
  int pd[2];
  int pe[2];
  int last_ptr;

  fnd_apb_arbiter #(.TIMEOUT(16), .MAX_VAL(9999)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .val0(val0), .dp0(dp0), .en0(en0), .ack0(ack0),
    .req1(req1), .val1(val1), .dp1(dp1), .en1(en1), .ack1(ack1),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PREADY(PREADY),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // APB slave: PREADY goes high in the ACCESS cycle after wait_n access cycles.
  always @(negedge PCLK) begin
    logic rdy;
    if (PSEL && PWRITE !== 1'b1) viol++;
    if (PENABLE && !PSEL) viol++;
    if (PSEL && !PENABLE) begin
      acc_cnt = 0;
      su_addr = PADDR;
      su_data = PWDATA;
      wait_n  = rand_wait ? int'($urandom_range(1, 3)) : 1;
      n_setup++;
    end else if (PSEL && PENABLE) begin
      acc_cnt++;
      n_access++;
      if (PADDR !== su_addr || PWDATA !== su_data) viol++;
    end else begin
      acc_cnt = 0;
    end
    rdy = ready_en && ((spur_en && PSEL && !PENABLE) ||
                       (PSEL && PENABLE && acc_cnt > wait_n));
    if (rdy && PSEL && PENABLE) wr_q.push_back({PADDR, PWDATA});
    PREADY = rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] exp_wr(int v, int d, int e, int k);
    int s;
    s = (v > 9999) ? 9999 : v;
    case (k)
      0:       return {4'h4, 32'(s)};
      1:       return {4'h8, 32'(d)};
      default: return {4'h0, 32'(e)};
    endcase
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(int r, int v, int d, int e);
    pv[r] = v; pd[r] = d; pe[r] = e;
    if (r == 0) begin
      req0 = 1'b1; val0 = 14'(v); dp0 = 4'(d); en0 = 1'(e);
    end else begin
      req1 = 1'b1; val1 = 14'(v); dp1 = 4'(d); en1 = 1'(e);
    end
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    tick();
    tick();
    PRESET = 1'b0;
    last_ptr = 1;
  endtask

  // Waits for the next ack; id = -1 when none arrives within the budget.
  task automatic wait_ack(input bit hold, output int id, output int cyc);
    id  = -1;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (ack0 || ack1) begin
        id = ack1 ? 1 : 0;
        if (!hold) begin
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) tick();
    n_checks++; if (PSEL !== 1'b0) begin n_fail++; $display("FAIL rst_psel got=%b exp=0", PSEL); end
    n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
    n_checks++; if (PWRITE !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite got=%b exp=0", PWRITE); end
    n_checks++; if (PADDR !== 4'h0) begin n_fail++; $display("FAIL rst_paddr got=%h exp=0", PADDR); end
    n_checks++; if (PWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata got=%h exp=0", PWDATA); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%b exp=00", {ack0, ack1}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0", grant_id); end
    PRESET = 1'b0;
    last_ptr = 1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  // Cycle-exact single transfer; optionally spurious PREADY in SETUP and payload
  // changes after the grant, neither of which may affect the transfer.
  task automatic test_single(input bit disturb);
    int base;
    int vi;
    bit exp_busy, exp_ack;
    base = wr_q.size();
    vi   = viol;
    spur_en = disturb;
    set_req(0, 1234, 4, 1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_busy = (c >= 1 && c <= 10);
      exp_ack  = (c == 10);
      n_checks++;
      if (busy !== exp_busy) begin n_fail++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
      n_checks++;
      if (ack0 !== exp_ack) begin n_fail++; $display("FAIL single_ack0 c=%0d got=%b exp=%b", c, ack0, exp_ack); end
      if (c == 1) begin
        n_checks++;
        if ({PSEL, PENABLE, PADDR} !== {1'b1, 1'b0, 4'h4}) begin
          n_fail++; $display("FAIL single_setup0 got=%b%b/%h exp=10/4", PSEL, PENABLE, PADDR);
        end
      end
      if (c == 2 && disturb) begin
        val0 = 14'd42; dp0 = 4'hf; en0 = 1'b0;
      end
      if (ack0) req0 = 1'b0;
    end
    spur_en = 1'b0;
    last_ptr = 0;
    n_checks++;
    if (wr_q.size() != base + 3) begin n_fail++; $display("FAIL single_nwr got=%0d exp=3", wr_q.size() - base); end
    for (int k = 0; k < 3; k++) begin
      logic [35:0] got;
      got = (base + k < wr_q.size()) ? wr_q[base + k] : 36'hx;
      n_checks++;
      if (got !== exp_wr(1234, 4, 1, k)) begin
        n_fail++; $display("FAIL single_wr%0d got=%h exp=%h", k, got, exp_wr(1234, 4, 1, k));
      end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", err); end
    n_checks++; if (viol != vi) begin n_fail++; $display("FAIL single_proto got=%0d exp=0", viol - vi); end
  endtask

  task automatic test_saturation();
    int base, id, cyc;
    base = wr_q.size();
    set_req(1, 12000, 9, 1);
    wait_ack(1'b0, id, cyc);
    last_ptr = 1;
    n_checks++; if (id !== 1) begin n_fail++; $display("FAIL sat_ack got=%0d exp=1", id); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL sat_grant got=%b exp=1", grant_id); end
    for (int k = 0; k < 3; k++) begin
      logic [35:0] got;
      got = (base + k < wr_q.size()) ? wr_q[base + k] : 36'hx;
      n_checks++;
      if (got !== exp_wr(12000, 9, 1, k)) begin
        n_fail++; $display("FAIL sat_wr%0d got=%h exp=%h", k, got, exp_wr(12000, 9, 1, k));
      end
    end
    tick();
  endtask

  // Serves whatever is pending and compares against the round-robin model.
  task automatic serve(input bit hold, input string tag, input bit renew);
    int base, id, cyc, exp;
    int ev, ed, ee;
    bit p0, p1;
    p0 = req0; p1 = req1;
    exp = (p0 && p1) ? (1 - last_ptr) : (p1 ? 1 : 0);
    ev = pv[exp]; ed = pd[exp]; ee = pe[exp];
    base = wr_q.size();
    wait_ack(hold, id, cyc);
    if (renew && id >= 0) set_req(id, int'($urandom_range(0, 16383)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    n_checks++;
    if (id !== exp) begin n_fail++; $display("FAIL %s_ack got=%0d exp=%0d", tag, id, exp); end
    n_checks++;
    if (grant_id !== 1'(exp)) begin n_fail++; $display("FAIL %s_grant got=%b exp=%0d", tag, grant_id, exp); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err got=%b exp=0", tag, err); end
    for (int k = 0; k < 3; k++) begin
      logic [35:0] got;
      got = (base + k < wr_q.size()) ? wr_q[base + k] : 36'hx;
      n_checks++;
      if (got !== exp_wr(ev, ed, ee, k)) begin
        n_fail++; $display("FAIL %s_wr%0d got=%h exp=%h", tag, k, got, exp_wr(ev, ed, ee, k));
      end
    end
    last_ptr = exp;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 100, 1, 1);
    set_req(1, 200, 2, 0);
    serve(1'b0, "both_a", 1'b0);
    serve(1'b0, "both_b", 1'b0);
    tick();
    set_req(0, 300, 3, 1);
    set_req(1, 400, 5, 1);
    for (int n = 0; n < 4; n++) serve(1'b1, "alt", 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int id, cyc, base, na, ns;
    base = wr_q.size();
    na = n_access;
    ns = n_setup;
    ready_en = 1'b0;
    set_req(0, 777, 6, 1);
    wait_ack(1'b0, id, cyc);
    n_checks++; if (id !== 0) begin n_fail++; $display("FAIL to_ack got=%0d exp=0", id); end
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL to_latency got=%0d exp=18", cyc); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", err); end
    n_checks++; if (n_access - na !== 16) begin n_fail++; $display("FAIL to_access got=%0d exp=16", n_access - na); end
    n_checks++; if (n_setup - ns !== 1) begin n_fail++; $display("FAIL to_setups got=%0d exp=1", n_setup - ns); end
    n_checks++; if (su_addr !== 4'h4) begin n_fail++; $display("FAIL to_addr got=%h exp=4", su_addr); end
    n_checks++; if (wr_q.size() != base) begin n_fail++; $display("FAIL to_wr got=%0d exp=0", wr_q.size() - base); end
    last_ptr = 0;
    ready_en = 1'b1;
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%b exp=1", err); end
    set_req(1, 55, 0, 1);
    serve(1'b0, "to_next", 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    int id, cyc, base;
    bit found;
    found = 1'b0;
    set_req(0, 1111, 1, 1);
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (PSEL && PENABLE && PADDR == 4'h8) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rm_find got=0 exp=1"); end
    PRESET = 1'b1;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, busy, ack0, ack1} !== 5'b0) begin
      n_fail++; $display("FAIL rm_outs got=%b exp=00000", {PSEL, PENABLE, busy, ack0, ack1});
    end
    n_checks++;
    if ({PADDR, PWDATA, grant_id, err} !== 38'b0) begin
      n_fail++; $display("FAIL rm_regs got=%h/%h/%b/%b exp=0", PADDR, PWDATA, grant_id, err);
    end
    req0 = 1'b0;
    set_req(1, 2222, 2, 1);
    base = wr_q.size();
    tick();
    tick();
    PRESET = 1'b0;
    last_ptr = 1;
    wait_ack(1'b0, id, cyc);
    n_checks++; if (id !== 1) begin n_fail++; $display("FAIL rm_ack got=%0d exp=1", id); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rm_grant got=%b exp=1", grant_id); end
    n_checks++;
    if (base + 2 >= wr_q.size() || wr_q[base] !== exp_wr(2222, 2, 1, 0)) begin
      n_fail++; $display("FAIL rm_wr0 got_n=%0d exp=%h", wr_q.size() - base, exp_wr(2222, 2, 1, 0));
    end
    tick();
  endtask

  task automatic test_random();
    int pat;
    rand_wait = 1'b1;
    for (int r = 0; r < 12; r++) begin
      pat = int'($urandom_range(1, 3));
      if (pat[0]) set_req(0, int'($urandom_range(0, 16383)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      if (pat[1]) set_req(1, int'($urandom_range(0, 16383)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      while (req0 || req1) serve(1'b0, "rnd", 1'b0);
      repeat (int'($urandom_range(1, 3))) tick();
    end
    rand_wait = 1'b0;
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    val0 = '0; val1 = '0; dp0 = '0; dp1 = '0; en0 = 1'b0; en1 = 1'b0;
    PRESET = 1'b1;
    last_ptr = 1;
    test_reset();
    test_single(1'b0);
    tick();
    test_single(1'b1);
    tick();
    test_saturation();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL apb_protocol got=%0d exp=0", viol); end
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
